mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single data port (port B) of the shared instruction/data RAM between the MIPS CPU data interface and a second bus master (DMA/loader). The CPU has default priority. The DMA can hold the port for locked bursts up to a cap, and a starvation counter guarantees it forward progress. The block sits between the CPU/DMA data buses and the RAM port B pins, in the `clk` domain; the address decoder's memory chip-select qualifies `cpu_req` upstream.

## Interface
Parameters:
- `ADDR_W`, 11, word-address width (RAM word index).
- `DATA_W`, 32, data width.
- `MAX_BURST`, 8, maximum consecutive DMA beats in one locked burst (≥2).
- `STARVE_LIM`, 4, consecutive denied DMA-request cycles before a forced DMA grant (≥1).

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU memory access this cycle.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in ADDR_W: word address.
- `cpu_wdata` in DATA_W: write data.
- `cpu_stall` out 1: CPU request not granted this cycle; hold request.
- `cpu_rvalid` out 1: `cpu_rdata` valid.
- `cpu_rdata` out DATA_W: read data.
- `dma_req` in 1: DMA access request.
- `dma_lock` in 1: request burst continuation after this beat.
- `dma_we` in 1: 1 = write.
- `dma_addr` in ADDR_W: word address.
- `dma_wdata` in DATA_W: write data.
- `dma_gnt` out 1: DMA beat accepted this cycle.
- `dma_rvalid` out 1: `dma_rdata` valid.
- `dma_rdata` out DATA_W: read data.
- `mem_en` out 1: RAM port enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, one cycle after `mem_en`.

## Operation
- FSM states:
  - `S_CPU`: CPU priority.
  - `S_DMA`: DMA owns a locked burst.
- Registers:
  - `state`
  - `burst_cnt` (width clog2(MAX_BURST)+1)
  - `starve_cnt` (width clog2(STARVE_LIM)+1)
  - `rd_owner_q` (NONE/CPU/DMA)
- At most one grant per cycle. The granted master's we/addr/wdata are muxed to `mem_*`, and `mem_en` = any grant. No grant: `mem_en`=0, and the other `mem_*` outputs are 0.
- `S_CPU` rules:
  - `starve_cnt`==STARVE_LIM and `dma_req`: grant DMA (forced); `cpu_stall`=`cpu_req`.
  - Else `cpu_req`: grant CPU. If `dma_req`, `starve_cnt`++.
  - Else `dma_req`: grant DMA.
  - Any DMA grant clears `starve_cnt`. `dma_req`=0 also clears it.
  - A DMA grant with `dma_lock`=1 moves to `S_DMA` with `burst_cnt`=1.
- `S_DMA` rules:
  - `dma_req`=1: grant DMA, `burst_cnt`++, `cpu_stall`=`cpu_req`. Return to `S_CPU` when `dma_lock`=0 or the new `burst_cnt`==MAX_BURST.
  - `dma_req`=0: serve the CPU as in `S_CPU` and return to `S_CPU`.
- Burst cap: the DMA cannot re-enter `S_DMA` in the cycle after the cap if `cpu_req`=1, because CPU priority applies.
- Read routing:
  - `rd_owner_q` records the granted reader (grant with we=0).
  - Next cycle: `cpu_rvalid`/`dma_rvalid` = (`rd_owner_q`==owner), and the matching `*_rdata` = `mem_rdata`.
  - Non-valid rdata outputs = 0.
- Writes produce no rvalid.

## Timing
- Grant, `cpu_stall` and `mem_*` are combinational from requests and registered state, with zero-cycle grant.
- Read data arrives at the requester exactly 1 cycle after its grant. Back-to-back grants pipeline at one access per cycle.
- Reset behaviour:
  - While `reset`=1: no grants, `mem_en`=0, `cpu_stall`=0, `dma_gnt`=0.
  - Next edge: `state`=`S_CPU`, counters=0, `rd_owner_q`=NONE, both rvalid=0.
  - A read granted in the cycle before reset is dropped (no rvalid).
- Worst-case CPU wait: MAX_BURST cycles per burst. Worst-case DMA wait: STARVE_LIM+1 cycles.
- Requesters must hold req/we/addr/wdata stable until granted.

## Structure
- Shared package `mem_bus_pkg`:
  - owner enum (`OWN_NONE`, `OWN_CPU`, `OWN_DMA`)
  - FSM state enum
  - default ADDR_W/DATA_W constants, also used by the address decoder and the DMA.
- Single module. No sub-modules; the datapath mux is inline.

## Test plan
- Reset: hold `reset` 2 cycles with both requests high → `mem_en`=0, `dma_gnt`=0, `cpu_stall`=0. First cycle after release → CPU granted, `starve_cnt`=0.
- CPU read 0x010 while idle → `mem_en`=1, `mem_addr`=0x010 same cycle. Next cycle `cpu_rvalid`=1, `cpu_rdata`=RAM[0x010], `dma_rvalid`=0.
- STARVE_LIM=4, CPU and DMA request continuously with lock=0 → DMA granted at every 5th cycle. `cpu_stall`=1 only in those cycles.
- DMA locked burst of 12 beats, MAX_BURST=8, CPU requesting from beat 2 → DMA gets beats 1–8, the CPU is granted on the 9th cycle, and DMA beats 9–12 follow under the starvation rules.
- DMA write 0xDEADBEEF@0x020 then CPU read 0x020 on the next cycle → CPU reads 0xDEADBEEF. No `dma_rvalid`.
- Reset asserted in the cycle after a DMA read grant → no `dma_rvalid`; FSM returns to `S_CPU` mid-burst.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: bus-owner and arbiter state encodings, default widths.
// The address decoder and the DMA engine use the same width defaults.
package mem_bus_pkg;

  localparam int unsigned MEM_ADDR_W = 11;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU data bus, DMA bus and RAM port-B pins seen by the port-B arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and RAM.
interface mem_port_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_lock;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_lock, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// RAM port-B arbiter: CPU has default priority, DMA gets capped locked bursts
// and a forced grant after STARVE_LIM consecutive denied cycles.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned BURST_W  = $clog2(MAX_BURST) + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIM) + 1;
  localparam logic [BURST_W-1:0]  BURST_CAP  = BURST_W'(MAX_BURST);
  localparam logic [STARVE_W-1:0] STARVE_CAP = STARVE_W'(STARVE_LIM);

  arb_state_e          r_state;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [STARVE_W-1:0] r_starve_cnt;
  owner_e              r_rd_owner_q;

  arb_state_e          w_state_nx;
  logic [BURST_W-1:0]  w_burst_nx;
  logic [STARVE_W-1:0] w_starve_nx;
  owner_e              w_owner_nx;
  logic                w_gnt_cpu;
  logic                w_gnt_dma;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_CPU;
      r_burst_cnt  <= '0;
      r_starve_cnt <= '0;
      r_rd_owner_q <= OWN_NONE;
    end else begin
      r_state      <= w_state_nx;
      r_burst_cnt  <= w_burst_nx;
      r_starve_cnt <= w_starve_nx;
      r_rd_owner_q <= w_owner_nx;
    end
  end

  // Grant decision lives here since both the next state and the mem mux depend on it.
  always_comb begin
    w_state_nx  = r_state;
    w_burst_nx  = r_burst_cnt;
    w_starve_nx = r_starve_cnt;
    w_gnt_cpu   = 1'b0;
    w_gnt_dma   = 1'b0;
    if (!reset) begin
      if (r_state == S_DMA && bus.dma_req) begin
        w_gnt_dma   = 1'b1;
        w_burst_nx  = r_burst_cnt + 1'b1;
        w_starve_nx = '0;
        if (!bus.dma_lock || w_burst_nx == BURST_CAP)
          w_state_nx = S_CPU;
      end else begin
        if (r_starve_cnt == STARVE_CAP && bus.dma_req) begin
          w_gnt_dma = 1'b1;
        end else if (bus.cpu_req) begin
          w_gnt_cpu = 1'b1;
          if (bus.dma_req)
            w_starve_nx = r_starve_cnt + 1'b1;
        end else if (bus.dma_req) begin
          w_gnt_dma = 1'b1;
        end
        if (w_gnt_dma || !bus.dma_req)
          w_starve_nx = '0;
        w_state_nx = S_CPU;
        if (w_gnt_dma && bus.dma_lock) begin
          w_state_nx = S_DMA;
          w_burst_nx = BURST_W'(1);
        end
      end
    end
    w_owner_nx = OWN_NONE;
    if (w_gnt_cpu && !bus.cpu_we)
      w_owner_nx = OWN_CPU;
    else if (w_gnt_dma && !bus.dma_we)
      w_owner_nx = OWN_DMA;
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    bus.mem_we  = 1'b0;
    if (w_gnt_cpu) begin
      bus.mem_we  = bus.cpu_we;
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
    end else if (w_gnt_dma) begin
      bus.mem_we  = bus.dma_we;
      w_mem_addr  = bus.dma_addr;
      w_mem_wdata = bus.dma_wdata;
    end
    bus.mem_en    = w_gnt_cpu | w_gnt_dma;
    bus.mem_addr  = w_mem_addr;
    bus.mem_wdata = w_mem_wdata;
    bus.dma_gnt   = w_gnt_dma;
    bus.cpu_stall = bus.cpu_req & ~w_gnt_cpu & ~reset;
    // Gating with reset drops a read granted in the cycle before reset.
    bus.cpu_rvalid = ~reset & (r_rd_owner_q == OWN_CPU);
    bus.dma_rvalid = ~reset & (r_rd_owner_q == OWN_DMA);
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;
  end

endmodule
